udp_tx_arbiter: RTL and testbench
=================================

// Module: udp_tx_arbiter
// PURPOSE
//  Shares the single UDP transmit path of the eth/arp/udp stack between N_CH byte-stream sources.
//  - Arbitrates round-robin, at packet boundaries only.
//  - Issues one header command per packet (dst IP/port, src port) from the per-channel config.
//  - Passes the payload through, truncating any packet longer than MAX_PKT_BYTES.
//  - Sits between the per-stream packetisers and the stack's UDP TX header/payload inputs.
// PARAMETERS
//  N_CH          4     number of source channels (2..16)
//  DATA_W        8     payload beat width in bits (one byte per beat)
//  MAX_PKT_BYTES 1472  max payload beats per packet; beats beyond this are truncated
// PORTS
//  ACLK          in   1           single clock; all logic rising-edge
//  ARESET        in   1           synchronous, active-high reset
//  s_tdata       in   N_CH*DATA_W source payload, channel c at [c*DATA_W +: DATA_W]
//  s_tvalid      in   N_CH        source beat valid
//  s_tlast       in   N_CH        source last beat of packet
//  s_tready      out  N_CH        source beat accepted
//  cfg_ch_en     in   N_CH        channel enable; sampled at arbitration only
//  cfg_dst_ip    in   N_CH*32     per-channel destination IPv4 address
//  cfg_dst_port  in   N_CH*16     per-channel destination UDP port
//  cfg_src_port  in   N_CH*16     per-channel source UDP port
//  hdr_valid     out  1           header command valid
//  hdr_ready     in   1           header command accepted by stack
//  hdr_dst_ip    out  32          latched destination IP
//  hdr_dst_port  out  16          latched destination port
//  hdr_src_port  out  16          latched source port
//  m_tdata       out  DATA_W      payload to stack
//  m_tvalid      out  1           payload valid
//  m_tlast       out  1           payload last
//  m_tready      in   1           stack accepts payload
//  grant_ch      out  CH_W        currently granted channel, CH_W = $clog2(N_CH)
//  trunc_pulse   out  1           1-cycle pulse when a packet is truncated
// BEHAVIOUR
//  Reset:
//  - All outputs 0, FSM=IDLE, rr pointer=0 (ch0 highest priority), beat counter 0.
//  - Reset mid-packet abandons the packet; no tlast is emitted.
//  FSM IDLE->HDR->DATA->(DROP)->IDLE:
//  - IDLE: req = s_tvalid & cfg_ch_en.
//    - If req!=0: grant the first set bit at or after the rr pointer (wrapping).
//    - Latch cfg fields and grant_ch; move the pointer to grant+1 (mod N_CH); go to HDR.
//    - Later cfg changes do not affect the in-flight packet.
//  - HDR: hdr_valid=1, fields held stable until hdr_ready; on hdr_ready go to DATA. No s_tready.
//  - DATA: combinational pass-through.
//    - m_tdata/m_tvalid/m_tlast = granted source; s_tready[g]=m_tready; all other s_tready=0.
//    - Beat counter increments per accepted beat; accepted beat with s_tlast -> IDLE.
//  - Truncation: on accepted beat number MAX_PKT_BYTES with s_tlast=0:
//    - Force m_tlast=1 on that beat; pulse trunc_pulse; go to DROP.
//    - If s_tlast=1 on exactly beat MAX_PKT_BYTES, the packet is normal (no pulse).
//  - DROP: m_tvalid=0, s_tready[g]=1; discard beats until s_tlast accepted, then IDLE.
//  Timing:
//  - Min cost is one IDLE cycle + one HDR cycle per packet.
//  - Header latency: hdr_valid rises the cycle after req is seen in IDLE.
//  Boundary rules:
//  - Channel disabled mid-packet: packet completes normally.
//  - A single requester is re-granted back-to-back.
//  - Zero-length packets do not exist (tlast is always on a data beat).
// CONFIGURATION
//  UDP_TX_ARB_STATS_EN defined:
//  - Adds output stat_pkt_cnt (N_CH*32): per-channel completed-packet count.
//  - Count increments on the accepted tlast beat, including truncated packets.
//  - Count wraps at 2^32; cleared by ARESET.
//  UDP_TX_ARB_STATS_EN undefined: port and counters absent; all other behaviour identical.
// STRUCTURE
//  Package udp_tx_arb_pkg:
//  - state_t enum {IDLE,HDR,DATA,DROP}.
//  - udp_hdr_t struct {dst_ip[31:0], dst_port[15:0], src_port[15:0]}.
//  Sub-module rr_arbiter #(N):
//  - req, ptr -> one-hot grant + index, combinational.
//  - Pointer register kept in udp_tx_arbiter.
// TESTING
//  - Reset: assert ARESET 5 cycles with all s_tvalid=1 -> all outputs 0 throughout; first grant ch0.
//  - Round robin: ch0..ch3 each hold a 4-beat packet, m_tready=1 -> grants 0,1,2,3.
//    - hdr_dst_port matches each channel's cfg; 16 beats out with 4 tlasts.
//  - Truncation (MAX_PKT_BYTES=8): ch1 sends 12 beats -> 8 beats out, m_tlast on beat 8.
//    - trunc_pulse=1 once; ch1 sees 12 s_tready beats.
//    - Variant: exactly 8 beats -> no trunc_pulse.
//  - Backpressure: hold hdr_ready=0 for 10 cycles, then toggle m_tready 1/0 -> hdr fields stable.
//    - No beat lost or duplicated; s_tready[g] mirrors m_tready.
//  - Enable/cfg change: clear cfg_ch_en[2] and change cfg_dst_ip[2] mid-packet.
//    - ch2 packet completes with the old IP; ch2 is not granted again.
//  - Stats (UDP_TX_ARB_STATS_EN): 3 packets on ch0 (one truncated) -> stat_pkt_cnt[0]=3, others 0.

Source files
------------

// File: rtl/udp_tx_arbiter_pkg.sv
// Shared types for the UDP transmit arbiter: FSM state encoding and the latched header command.
package udp_tx_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2,
        DROP = 2'd3
    } state_t;

    typedef struct packed {
        logic [31:0] dst_ip;
        logic [15:0] dst_port;
        logic [15:0] src_port;
    } udp_hdr_t;

endpackage

// File: rtl/udp_tx_arbiter_if.sv
// Source streams, header command and payload stream of the UDP TX arbiter.
// The master modport is the arbiter's view; slave is the surrounding sources and stack.
interface udp_tx_arbiter_if #(
    parameter int N_CH   = 4,
    parameter int DATA_W = 8
);
    logic [N_CH*DATA_W-1:0] s_tdata;
    logic [N_CH-1:0]        s_tvalid;
    logic [N_CH-1:0]        s_tlast;
    logic [N_CH-1:0]        s_tready;

    logic                   hdr_valid;
    logic                   hdr_ready;
    logic [31:0]            hdr_dst_ip;
    logic [15:0]            hdr_dst_port;
    logic [15:0]            hdr_src_port;

    logic [DATA_W-1:0]      m_tdata;
    logic                   m_tvalid;
    logic                   m_tlast;
    logic                   m_tready;

    modport master (
        input  s_tdata, s_tvalid, s_tlast, hdr_ready, m_tready,
        output s_tready, hdr_valid, hdr_dst_ip, hdr_dst_port, hdr_src_port,
               m_tdata, m_tvalid, m_tlast
    );

    modport slave (
        output s_tdata, s_tvalid, s_tlast, hdr_ready, m_tready,
        input  s_tready, hdr_valid, hdr_dst_ip, hdr_dst_port, hdr_src_port,
               m_tdata, m_tvalid, m_tlast
    );
endinterface

// File: rtl/udp_tx_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first request at or after ptr_i, wrapping past N-1.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            int j;
            j = int'(ptr_i) + i;
            if (j >= N) j = j - N;
            if (!valid_o && req_i[j]) begin
                valid_o  = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/udp_tx_arbiter.sv
// Shares the stack's UDP TX path between N_CH sources, one packet per grant, with truncation.
// Optional per-channel packet counters are built when UDP_TX_ARB_STATS_EN is defined.
//
// state | meaning
// IDLE  | waiting for an enabled, valid source; picks one round-robin
// HDR   | header command offered to the stack, sources stalled
// DATA  | granted source passed through to the stack
// DROP  | packet hit the length limit; remaining source beats discarded
module udp_tx_arbiter
    import udp_tx_arb_pkg::*;
#(
    parameter  int N_CH          = 4,
    parameter  int DATA_W        = 8,
    parameter  int MAX_PKT_BYTES = 1472,
    localparam int CH_W          = $clog2(N_CH)
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    udp_tx_arbiter_if.master     bus,
    input  logic [N_CH-1:0]      cfg_ch_en,
    input  logic [N_CH*32-1:0]   cfg_dst_ip,
    input  logic [N_CH*16-1:0]   cfg_dst_port,
    input  logic [N_CH*16-1:0]   cfg_src_port,
    output logic [CH_W-1:0]      grant_ch,
    output logic                 trunc_pulse
`ifdef UDP_TX_ARB_STATS_EN
   ,output logic [N_CH*32-1:0]   stat_pkt_cnt
`endif
);

    localparam int CNT_W = $clog2(MAX_PKT_BYTES + 1);

    state_t            state_q, state_d;
    logic [CH_W-1:0]   ptr_q, ptr_d;
    logic [CH_W-1:0]   grant_q, grant_d;
    logic [N_CH-1:0]   gnt_oh_q, gnt_oh_d;
    udp_hdr_t          hdr_q, hdr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [N_CH-1:0]   req;
    logic [N_CH-1:0]   arb_oh;
    logic [CH_W-1:0]   arb_idx;
    logic              arb_vld;

    logic [DATA_W-1:0] sel_tdata;
    logic              sel_tvalid;
    logic              sel_tlast;
    logic              beat_acc;
    logic              at_max;

    logic [N_CH-1:0]   s_tready_c;
    logic              hdr_valid_c;
    logic [DATA_W-1:0] m_tdata_c;
    logic              m_tvalid_c;
    logic              m_tlast_c;
    logic              trunc_c;

    assign req = bus.s_tvalid & cfg_ch_en;

    rr_arbiter #(.N(N_CH)) u_rr (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_oh),
        .idx_o   (arb_idx),
        .valid_o (arb_vld)
    );

    assign sel_tdata  = bus.s_tdata[grant_q*DATA_W +: DATA_W];
    assign sel_tvalid = bus.s_tvalid[grant_q];
    assign sel_tlast  = bus.s_tlast[grant_q];
    assign beat_acc   = sel_tvalid & bus.m_tready;
    assign at_max     = (cnt_q == CNT_W'(MAX_PKT_BYTES - 1));

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        gnt_oh_d    = gnt_oh_q;
        hdr_d       = hdr_q;
        cnt_d       = cnt_q;
        s_tready_c  = '0;
        hdr_valid_c = 1'b0;
        m_tdata_c   = '0;
        m_tvalid_c  = 1'b0;
        m_tlast_c   = 1'b0;
        trunc_c     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (arb_vld) begin
                    grant_d        = arb_idx;
                    gnt_oh_d       = arb_oh;
                    hdr_d.dst_ip   = cfg_dst_ip[arb_idx*32 +: 32];
                    hdr_d.dst_port = cfg_dst_port[arb_idx*16 +: 16];
                    hdr_d.src_port = cfg_src_port[arb_idx*16 +: 16];
                    ptr_d          = (arb_idx == CH_W'(N_CH - 1)) ? '0 : arb_idx + 1'b1;
                    cnt_d          = '0;
                    state_d        = HDR;
                end
            end
            HDR: begin
                hdr_valid_c = 1'b1;
                if (bus.hdr_ready) state_d = DATA;
            end
            DATA: begin
                m_tdata_c  = sel_tdata;
                m_tvalid_c = sel_tvalid;
                m_tlast_c  = sel_tlast;
                s_tready_c = gnt_oh_q & {N_CH{bus.m_tready}};
                if (beat_acc) begin
                    cnt_d = cnt_q + 1'b1;
                    if (sel_tlast) begin
                        state_d = IDLE;
                    end else if (at_max) begin
                        // Close the packet on the stack side; the source tail is eaten in DROP.
                        m_tlast_c = 1'b1;
                        trunc_c   = 1'b1;
                        state_d   = DROP;
                    end
                end
            end
            DROP: begin
                s_tready_c = gnt_oh_q;
                if (sel_tvalid && sel_tlast) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            grant_q  <= '0;
            gnt_oh_q <= '0;
            hdr_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            gnt_oh_q <= gnt_oh_d;
            hdr_q    <= hdr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.s_tready     = s_tready_c;
    assign bus.hdr_valid    = hdr_valid_c;
    assign bus.hdr_dst_ip   = hdr_q.dst_ip;
    assign bus.hdr_dst_port = hdr_q.dst_port;
    assign bus.hdr_src_port = hdr_q.src_port;
    assign bus.m_tdata      = m_tdata_c;
    assign bus.m_tvalid     = m_tvalid_c;
    assign bus.m_tlast      = m_tlast_c;
    assign grant_ch         = grant_q;
    assign trunc_pulse      = trunc_c;

`ifdef UDP_TX_ARB_STATS_EN
    logic [31:0] stat_q [N_CH];
    logic        pkt_done;

    // One count per packet on its stack-side last beat, truncated packets included.
    assign pkt_done = (state_q == DATA) && beat_acc && (sel_tlast || at_max);

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int c = 0; c < N_CH; c++) stat_q[c] <= '0;
        end else if (pkt_done) begin
            stat_q[grant_q] <= stat_q[grant_q] + 32'd1;
        end
    end

    always_comb begin
        stat_pkt_cnt = '0;
        for (int c = 0; c < N_CH; c++) stat_pkt_cnt[c*32 +: 32] = stat_q[c];
    end
`endif

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Directed bench for udp_tx_arbiter with a 4-channel, 8-beat-limit build.
// Source beats carry channel*32 + beat index so ordering and loss are visible on the output.
module tb_udp_tx_arbiter;

    logic         ACLK = 1'b0;
    logic         ARESET = 1'b1;
    logic [3:0]   cfg_ch_en;
    logic [127:0] cfg_dst_ip;
    logic [63:0]  cfg_dst_port;
    logic [63:0]  cfg_src_port;
    logic [1:0]   grant_ch;
    logic         trunc_pulse;
`ifdef UDP_TX_ARB_STATS_EN
    logic [127:0] stat_pkt_cnt;
`endif

    udp_tx_arbiter_if #(.N_CH(4), .DATA_W(8)) bus ();

    udp_tx_arbiter #(.N_CH(4), .DATA_W(8), .MAX_PKT_BYTES(8)) dut (
        .ACLK         (ACLK),
        .ARESET       (ARESET),
        .bus          (bus),
        .cfg_ch_en    (cfg_ch_en),
        .cfg_dst_ip   (cfg_dst_ip),
        .cfg_dst_port (cfg_dst_port),
        .cfg_src_port (cfg_src_port),
        .grant_ch     (grant_ch),
        .trunc_pulse  (trunc_pulse)
`ifdef UDP_TX_ARB_STATS_EN
       ,.stat_pkt_cnt (stat_pkt_cnt)
`endif
    );

    always #5 ACLK = ~ACLK;

    int tests = 0;
    int fails = 0;

    int src_len [4];
    int src_beat[4];
    int src_npk [4];
    int acc_cnt [4];

    logic [7:0]  out_q [$];
    int          gnt_q [$];
    logic [31:0] ip_q  [$];
    logic [15:0] port_q[$];
    int tlast_cnt, tlast_pos, trunc_cnt;
    bit chk_rst, chk_mirror, toggle_rdy;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit src_active();
        bit a = 1'b0;
        for (int c = 0; c < 4; c++) if (src_beat[c] < src_len[c]) a = 1'b1;
        return a;
    endfunction

    task automatic drive_srcs();
        for (int c = 0; c < 4; c++) begin
            bus.s_tvalid[c]        = (src_beat[c] < src_len[c]);
            bus.s_tdata[c*8 +: 8]  = 8'(c*32 + src_beat[c]);
            bus.s_tlast[c]         = (src_beat[c] < src_len[c]) && (src_beat[c] == src_len[c] - 1);
        end
    endtask

    task automatic load(input int c, input int len, input int npk);
        src_len[c]  = len;
        src_beat[c] = 0;
        src_npk[c]  = npk;
        drive_srcs();
    endtask

    task automatic clear_mon();
        out_q.delete();
        gnt_q.delete();
        ip_q.delete();
        port_q.delete();
        tlast_cnt = 0;
        tlast_pos = 0;
        trunc_cnt = 0;
        for (int c = 0; c < 4; c++) acc_cnt[c] = 0;
    endtask

    // Sample at the falling edge, then update stimulus just after the rising edge.
    task automatic cycle();
        logic [3:0] acc;
        @(negedge ACLK);
        acc = bus.s_tvalid & bus.s_tready;
        if (bus.m_tvalid && bus.m_tready) begin
            out_q.push_back(bus.m_tdata);
            if (bus.m_tlast) begin
                tlast_cnt++;
                tlast_pos = out_q.size();
            end
        end
        if (bus.hdr_valid && bus.hdr_ready) begin
            gnt_q.push_back(int'(grant_ch));
            ip_q.push_back(bus.hdr_dst_ip);
            port_q.push_back(bus.hdr_dst_port);
        end
        if (trunc_pulse) trunc_cnt++;
        for (int c = 0; c < 4; c++) acc_cnt[c] += int'(acc[c]);
        if (chk_rst)
            check("rst_outputs", {bus.hdr_valid, bus.m_tvalid, bus.m_tlast, bus.s_tready, trunc_pulse,
                                  grant_ch, bus.m_tdata, bus.hdr_dst_ip, bus.hdr_dst_port, bus.hdr_src_port}, '0);
        if (chk_mirror && bus.m_tvalid)
            check("tready_mirror", bus.s_tready, 4'(bus.m_tready) << grant_ch);
        @(posedge ACLK);
        #1;
        for (int c = 0; c < 4; c++) begin
            if (acc[c]) begin
                src_beat[c]++;
                if (src_beat[c] == src_len[c] && src_npk[c] > 1) begin
                    src_npk[c]--;
                    src_beat[c] = 0;
                end
            end
        end
        if (toggle_rdy) bus.m_tready = ~bus.m_tready;
        drive_srcs();
    endtask

    task automatic run_drain(input int max);
        int n = 0;
        while (src_active() && n < max) begin
            cycle();
            n++;
        end
        check("drain_timeout", n < max, 1'b1);
        repeat (3) cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        chk_rst = 0; chk_mirror = 0; toggle_rdy = 0;
        for (int c = 0; c < 4; c++) begin
            cfg_dst_ip[c*32 +: 32]   = 32'h0A00_0000 + 32'(c);
            cfg_dst_port[c*16 +: 16] = 16'h1000 + 16'(c);
            cfg_src_port[c*16 +: 16] = 16'h2000 + 16'(c);
            src_len[c] = 0; src_beat[c] = 0; src_npk[c] = 0;
        end
        cfg_ch_en     = 4'hF;
        bus.hdr_ready = 1'b1;
        bus.m_tready  = 1'b1;
        bus.s_tdata   = '0;
        bus.s_tvalid  = '0;
        bus.s_tlast   = '0;
        clear_mon();

        // Reset held with every source requesting; then first grant goes to ch0.
        for (int c = 0; c < 4; c++) load(c, 4, 1);
        @(posedge ACLK);
        #1;
        chk_rst = 1;
        repeat (5) cycle();
        chk_rst = 0;
        ARESET = 1'b0;
        check("hdr_lat_idle", bus.hdr_valid, 1'b0);
        cycle();
        check("hdr_lat_rise", bus.hdr_valid, 1'b1);
        check("first_grant", grant_ch, 2'd0);
        run_drain(200);
        check("rr_n_hdr", gnt_q.size(), 4);
        for (int c = 0; c < 4; c++) begin
            check("rr_grant", gnt_q[c], c);
            check("rr_dst_port", port_q[c], 16'h1000 + 16'(c));
        end
        check("rr_beats", out_q.size(), 16);
        check("rr_tlasts", tlast_cnt, 4);
        check("rr_trunc", trunc_cnt, 0);
        for (int i = 0; i < 16; i++) check("rr_data", out_q[i], 8'((i/4)*32 + i%4));

        // 12-beat packet on ch1 against an 8-beat limit.
        clear_mon();
        load(1, 12, 1);
        run_drain(100);
        check("tr_grant", gnt_q[0], 1);
        check("tr_beats", out_q.size(), 8);
        check("tr_tlasts", tlast_cnt, 1);
        check("tr_tlast_pos", tlast_pos, 8);
        check("tr_pulses", trunc_cnt, 1);
        check("tr_src_acc", acc_cnt[1], 12);
        check("tr_data7", out_q[7], 8'd39);

        // Exactly 8 beats is a normal packet.
        clear_mon();
        load(1, 8, 1);
        run_drain(100);
        check("ex_beats", out_q.size(), 8);
        check("ex_tlast_pos", tlast_pos, 8);
        check("ex_pulses", trunc_cnt, 0);
        check("ex_src_acc", acc_cnt[1], 8);

        // Header backpressure, then payload backpressure toggling every cycle.
        clear_mon();
        bus.hdr_ready = 1'b0;
        load(3, 5, 1);
        cycle();
        repeat (9) begin
            check("bp_hdr_valid", bus.hdr_valid, 1'b1);
            check("bp_hdr_ip", bus.hdr_dst_ip, 32'h0A00_0003);
            check("bp_hdr_dport", bus.hdr_dst_port, 16'h1003);
            check("bp_hdr_sport", bus.hdr_src_port, 16'h2003);
            check("bp_no_ready", bus.s_tready, 4'h0);
            cycle();
        end
        bus.hdr_ready = 1'b1;
        chk_mirror = 1;
        toggle_rdy = 1;
        run_drain(100);
        chk_mirror = 0;
        toggle_rdy = 0;
        bus.m_tready = 1'b1;
        check("bp_beats", out_q.size(), 5);
        for (int i = 0; i < 5; i++) check("bp_data", out_q[i], 8'(96 + i));
        check("bp_tlasts", tlast_cnt, 1);

        // Disable ch2 and change its IP while its packet is in flight.
        clear_mon();
        load(2, 6, 1);
        repeat (4) cycle();
        cfg_ch_en[2] = 1'b0;
        cfg_dst_ip[2*32 +: 32] = 32'hC0A8_0002;
        check("en_ip_hold", bus.hdr_dst_ip, 32'h0A00_0002);
        run_drain(100);
        check("en_grant", gnt_q[0], 2);
        check("en_hdr_ip", ip_q[0], 32'h0A00_0002);
        check("en_beats", out_q.size(), 6);
        check("en_tlasts", tlast_cnt, 1);
        clear_mon();
        load(2, 3, 1);
        load(0, 2, 1);
        repeat (20) cycle();
        check("en_n_hdr", gnt_q.size(), 1);
        check("en_other_grant", gnt_q[0], 0);
        check("en_ch2_idle", acc_cnt[2], 0);
        check("en_other_beats", out_q.size(), 2);
        src_len[2] = 0;
        drive_srcs();
        cfg_ch_en[2] = 1'b1;

        // A lone requester is granted again for its next packet.
        clear_mon();
        load(1, 3, 2);
        run_drain(100);
        check("b2b_n_hdr", gnt_q.size(), 2);
        check("b2b_g0", gnt_q[0], 1);
        check("b2b_g1", gnt_q[1], 1);
        check("b2b_beats", out_q.size(), 6);
        check("b2b_tlasts", tlast_cnt, 2);
        check("b2b_data3", out_q[3], 8'd32);

`ifdef UDP_TX_ARB_STATS_EN
        ARESET = 1'b1;
        repeat (2) cycle();
        ARESET = 1'b0;
        check("st_clear", stat_pkt_cnt, '0);
        load(0, 3, 1);
        run_drain(100);
        load(0, 10, 1);
        run_drain(100);
        load(0, 2, 1);
        run_drain(100);
        check("st_counts", stat_pkt_cnt, {32'd0, 32'd0, 32'd0, 32'd3});
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
